fastserial_tx_arbiter: RTL and testbench

FASTSERIAL_TX_ARBITER -- requirements
Module: fastserial_tx_arbiter

---
 rtl/fastserial_tx_arbiter_if.sv | 32 +++
 rtl/fastserial_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_fastserial_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fastserial_tx_arbiter_if.sv
// Byte-stream handshake bundle between two requesters, the arbiter and tx_fastserial.
interface fastserial_tx_arbiter_if;
  // Requester 0 (Avalon bytes bridge)
  logic [7:0] i_s0_data;
  logic       i_s0_valid;
  logic       i_s0_last;
  logic       o_s0_ready;
  // Requester 1 (telemetry)
  logic [7:0] i_s1_data;
  logic       i_s1_valid;
  logic       i_s1_last;
  logic       o_s1_ready;
  // tx_fastserial side and status
  logic [7:0] o_fsdata;
  logic       o_fswrite;
  logic       i_fsbusy;
  logic [1:0] o_grant;
  logic       o_abort;
  logic       o_err_busy;

  // Arbiter view
  modport slave (
    input  i_s0_data, i_s0_valid, i_s0_last, i_s1_data, i_s1_valid, i_s1_last, i_fsbusy,
    output o_s0_ready, o_s1_ready, o_fsdata, o_fswrite, o_grant, o_abort, o_err_busy
  );

  // Requester / serializer view
  modport master (
    output i_s0_data, i_s0_valid, i_s0_last, i_s1_data, i_s1_valid, i_s1_last, i_fsbusy,
    input  o_s0_ready, o_s1_ready, o_fsdata, o_fswrite, o_grant, o_abort, o_err_busy
  );
endinterface

// File: rtl/fastserial_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding bytes from two requesters into tx_fastserial.
module fastserial_tx_arbiter #(
  parameter int unsigned GAP_TIMEOUT = 1024,
  parameter int unsigned BUSY_WAIT   = 4
) (
  input logic                    i_clk,
  input logic                    i_reset,
  fastserial_tx_arbiter_if.slave fs
);

  localparam int unsigned GapW  = $clog2(GAP_TIMEOUT + 1);
  localparam int unsigned BusyW = $clog2(BUSY_WAIT + 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_TIMEOUT - 1);
  localparam logic [BusyW-1:0] BusyLast = BusyW'(BUSY_WAIT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StWaitBusy, StWaitDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_served_q, last_served_d;  // 1: requester 1 was served last
  logic [7:0]       fsdata_q, fsdata_d;
  logic             last_q, last_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [BusyW-1:0] busy_q, busy_d;

  logic       ready0, ready1, fswrite, abort, err_busy, complete;
  logic       own_valid, own_last, pick_s1;
  logic [7:0] own_data;

  assign own_valid = grant_q[1] ? fs.i_s1_valid : fs.i_s0_valid;
  assign own_data  = grant_q[1] ? fs.i_s1_data  : fs.i_s0_data;
  assign own_last  = grant_q[1] ? fs.i_s1_last  : fs.i_s0_last;
  // Requester 1 wins if alone, or on a tie when requester 0 was served last
  assign pick_s1   = fs.i_s1_valid & (~fs.i_s0_valid | ~last_served_q);

  // Next-state, datapath capture and pulse outputs
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    fsdata_d      = fsdata_q;
    last_d        = last_q;
    gap_d         = gap_q;
    busy_d        = busy_q;
    ready0        = 1'b0;
    ready1        = 1'b0;
    fswrite       = 1'b0;
    abort         = 1'b0;
    err_busy      = 1'b0;
    complete      = 1'b0;

    case (state_q)
      StIdle: begin
        if (fs.i_s0_valid || fs.i_s1_valid) begin
          grant_d = pick_s1 ? 2'b10 : 2'b01;
          gap_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        ready0 = grant_q[0] & ~fs.i_fsbusy;
        ready1 = grant_q[1] & ~fs.i_fsbusy;
        if (own_valid && !fs.i_fsbusy) begin
          fsdata_d = own_data;
          last_d   = own_last;
          gap_d    = '0;
          state_d  = StWrite;
        end else if (!own_valid) begin
          if (gap_q == GapLast) begin
            abort         = 1'b1;
            grant_d       = 2'b00;
            last_served_d = grant_q[1];
            gap_d         = '0;
            state_d       = StIdle;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      StWrite: begin
        fswrite = 1'b1;
        busy_d  = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (fs.i_fsbusy) begin
          state_d = StWaitDone;
        end else if (busy_q == BusyLast) begin
          // Serializer never acknowledged: flag it and treat the byte as sent
          err_busy = 1'b1;
          complete = 1'b1;
        end else begin
          busy_d = busy_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!fs.i_fsbusy) complete = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (complete) begin
      if (last_q) begin
        grant_d       = 2'b00;
        last_served_d = grant_q[1];
        state_d       = StIdle;
      end else begin
        state_d = StLoad;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= StIdle;
      grant_q       <= 2'b00;
      last_served_q <= 1'b1;
      fsdata_q      <= 8'h00;
      last_q        <= 1'b0;
      gap_q         <= '0;
      busy_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
      fsdata_q      <= fsdata_d;
      last_q        <= last_d;
      gap_q         <= gap_d;
      busy_q        <= busy_d;
    end
  end

  // Outputs are forced to idle values while reset is held so a mid-packet reset is silent
  assign fs.o_s0_ready = ready0 & ~i_reset;
  assign fs.o_s1_ready = ready1 & ~i_reset;
  assign fs.o_fswrite  = fswrite & ~i_reset;
  assign fs.o_abort    = abort & ~i_reset;
  assign fs.o_err_busy = err_busy & ~i_reset;
  assign fs.o_grant    = i_reset ? 2'b00 : grant_q;
  assign fs.o_fsdata   = i_reset ? 8'h00 : fsdata_q;

endmodule

// File: tb/tb_fastserial_tx_arbiter.sv
// Scoreboard bench for fastserial_tx_arbiter: sources, serializer responder and monitor run
// as independent processes; expected bytes and status pulses come from a packet-level model.
module tb_fastserial_tx_arbiter;

  localparam int GapTimeout = 8;
  localparam int BusyWait   = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] gap;   // idle cycles the source inserts after this beat is accepted
  } beat_t;

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   resp_mode = 1;  // 0: random, 1: rise after 1 / hold 10, 2: never busy

  beat_t s0_q[$];
  beat_t s1_q[$];
  exp_t  exp_q[$];
  int    err_exp[$];
  int    strobe_log[$];
  int    abort_log[$];
  logic  acc0 = 1'b0;
  logic  acc1 = 1'b0;

  fastserial_tx_arbiter_if fs ();

  fastserial_tx_arbiter #(
    .GAP_TIMEOUT(GapTimeout),
    .BUSY_WAIT  (BusyWait)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .fs     (fs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, 32'(fs.o_grant), 32'h0);
    check({tag, "_fswrite"}, 32'(fs.o_fswrite), 32'h0);
    check({tag, "_fsdata"}, 32'(fs.o_fsdata), 32'h0);
    check({tag, "_abort"}, 32'(fs.o_abort), 32'h0);
    check({tag, "_err_busy"}, 32'(fs.o_err_busy), 32'h0);
    check({tag, "_s0_ready"}, 32'(fs.o_s0_ready), 32'h0);
    check({tag, "_s1_ready"}, 32'(fs.o_s1_ready), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s0_q.delete();
    s1_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    strobe_log.delete();
    abort_log.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!(exp_q.size() == 0 && !fs.i_fsbusy && fs.o_grant == 2'b00 && n > 2) && n < 3000);
    if (n >= 3000) fail(name, $sformatf("still busy after 3000 cycles, %0d bytes outstanding",
                                        exp_q.size()));
  endtask

  // Requester 0 source
  initial begin : src0
    int bub;
    bub = 0;
    forever begin
      @(negedge clk);
      if (acc0 && s0_q.size() > 0) begin
        bub = int'(s0_q[0].gap);
        void'(s0_q.pop_front());
      end
      if (bub > 0) begin
        fs.i_s0_valid = 1'b0;
        bub--;
      end else if (s0_q.size() > 0) begin
        fs.i_s0_valid = 1'b1;
        fs.i_s0_data  = s0_q[0].data;
        fs.i_s0_last  = s0_q[0].last;
      end else begin
        fs.i_s0_valid = 1'b0;
      end
      #1 acc0 = fs.i_s0_valid & fs.o_s0_ready;
    end
  end

  // Requester 1 source
  initial begin : src1
    int bub;
    bub = 0;
    forever begin
      @(negedge clk);
      if (acc1 && s1_q.size() > 0) begin
        bub = int'(s1_q[0].gap);
        void'(s1_q.pop_front());
      end
      if (bub > 0) begin
        fs.i_s1_valid = 1'b0;
        bub--;
      end else if (s1_q.size() > 0) begin
        fs.i_s1_valid = 1'b1;
        fs.i_s1_data  = s1_q[0].data;
        fs.i_s1_last  = s1_q[0].last;
      end else begin
        fs.i_s1_valid = 1'b0;
      end
      #1 acc1 = fs.i_s1_valid & fs.o_s1_ready;
    end
  end

  // Serializer stand-in: answers each strobe with a busy pulse, or stays silent
  initial begin : responder
    int d;
    int h;
    fs.i_fsbusy = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (fs.o_fswrite) begin
        if (resp_mode == 2 || (resp_mode == 0 && $urandom_range(0, 3) == 0)) begin
          err_exp.push_back(cyc + BusyWait);
        end else begin
          d = (resp_mode == 1) ? 1 : int'($urandom_range(1, 3));
          h = (resp_mode == 1) ? 10 : int'($urandom_range(1, 6));
          repeat (d) @(negedge clk);
          fs.i_fsbusy = 1'b1;
          repeat (h) @(negedge clk);
          fs.i_fsbusy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every write strobe and error pulse
  initial begin : monitor
    exp_t e;
    logic abort_prev;
    abort_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        abort_prev = 1'b0;
      end else begin
        if (fs.o_fswrite) begin
          strobe_log.push_back(cyc);
          if (exp_q.size() == 0) begin
            fail("write_unexpected", $sformatf("strobe with data %0h, none expected", fs.o_fsdata));
          end else begin
            e = exp_q.pop_front();
            check("write_data", 32'(fs.o_fsdata), 32'(e.data));
            check("write_grant", 32'(fs.o_grant), e.src ? 32'h2 : 32'h1);
          end
        end
        if (fs.o_err_busy) begin
          if (err_exp.size() == 0) fail("err_busy_unexpected", "pulse seen, none expected");
          else check("err_busy_cycle", 32'(cyc), 32'(err_exp.pop_front()));
        end
        if (abort_prev) check("grant_after_abort", 32'(fs.o_grant), 32'h0);
        if (fs.o_abort) abort_log.push_back(cyc);
        abort_prev = fs.o_abort;
        check("s0_ready_nonowner", 32'(fs.o_s0_ready & ~fs.o_grant[0]), 32'h0);
        check("s1_ready_nonowner", 32'(fs.o_s1_ready & ~fs.o_grant[1]), 32'h0);
      end
    end
  end

  initial begin : main
    beat_t b;
    beat_t m[2][$];
    int    idx[2];
    int    turn;
    int    s;
    int    n;

    rst = 1'b1;
    fs.i_s0_data = 8'h00; fs.i_s0_last = 1'b0; fs.i_s0_valid = 1'b0;
    fs.i_s1_data = 8'h00; fs.i_s1_last = 1'b0; fs.i_s1_valid = 1'b0;

    // Reset state, during and after reset
    repeat (3) @(negedge clk);
    #3 check_quiet("during_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3 check_quiet("after_reset");

    // Single byte 0x41 from requester 0
    resp_mode = 1;
    @(posedge clk); #1;
    s0_q.push_back('{data: 8'h41, last: 1'b1, gap: 2'd0});
    exp_q.push_back('{src: 1'b0, data: 8'h41});
    wait_idle("single_byte");
    check("single_strobes", 32'(strobe_log.size()), 32'd1);
    check("single_fsdata_held", 32'(fs.o_fsdata), 32'h41);

    // Packet lock: requester 1 waits for the whole 3-byte packet of requester 0
    do_reset();
    @(posedge clk); #1;
    s0_q.push_back('{data: 8'h10, last: 1'b0, gap: 2'd0});
    s0_q.push_back('{data: 8'h11, last: 1'b0, gap: 2'd0});
    s0_q.push_back('{data: 8'h12, last: 1'b1, gap: 2'd0});
    s1_q.push_back('{data: 8'h20, last: 1'b1, gap: 2'd0});
    exp_q.push_back('{src: 1'b0, data: 8'h10});
    exp_q.push_back('{src: 1'b0, data: 8'h11});
    exp_q.push_back('{src: 1'b0, data: 8'h12});
    exp_q.push_back('{src: 1'b1, data: 8'h20});
    wait_idle("packet_lock");

    // Gap timeout with a silent serializer: busy error, then abort, then requester 1 served
    do_reset();
    resp_mode = 2;
    @(posedge clk); #1;
    s0_q.push_back('{data: 8'h30, last: 1'b0, gap: 2'd0});
    s1_q.push_back('{data: 8'h77, last: 1'b1, gap: 2'd0});
    exp_q.push_back('{src: 1'b0, data: 8'h30});
    exp_q.push_back('{src: 1'b1, data: 8'h77});
    wait_idle("gap_timeout");
    check("abort_count", 32'(abort_log.size()), 32'd1);
    if (abort_log.size() > 0 && strobe_log.size() > 0)
      check("abort_cycle", 32'(abort_log[0]), 32'(strobe_log[0] + BusyWait + GapTimeout));
    check("err_busy_all_seen", 32'(err_exp.size()), 32'd0);

    // Reset while byte 2 of 3 is in flight
    do_reset();
    resp_mode = 1;
    @(posedge clk); #1;
    s0_q.push_back('{data: 8'h51, last: 1'b0, gap: 2'd0});
    s0_q.push_back('{data: 8'h52, last: 1'b0, gap: 2'd0});
    s0_q.push_back('{data: 8'h53, last: 1'b1, gap: 2'd0});
    exp_q.push_back('{src: 1'b0, data: 8'h51});
    exp_q.push_back('{src: 1'b0, data: 8'h52});
    n = 0;
    while (strobe_log.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail("mid_reset_setup", "second strobe never seen");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    s0_q.delete();
    #3 check_quiet("mid_reset_during");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3 check_quiet("mid_reset_after");
    repeat (40) @(negedge clk);
    check("mid_reset_strobes", 32'(strobe_log.size()), 32'd2);
    check("mid_reset_aborts", 32'(abort_log.size()), 32'd0);
    check("mid_reset_pending", 32'(exp_q.size()), 32'd0);

    // Randomized packets from both requesters against a packet-level round-robin model
    do_reset();
    resp_mode = 0;
    for (int src = 0; src < 2; src++) begin
      m[src].delete();
      for (int p = 0; p < 8 + 4 * src; p++) begin
        int len;
        len = int'($urandom_range(1, 4));
        for (int k = 0; k < len; k++) begin
          b.data = 8'($urandom);
          b.last = (k == len - 1);
          b.gap  = 2'($urandom_range(0, 3));
          m[src].push_back(b);
        end
      end
    end
    // Whole packets alternate, requester 0 first after reset; leftovers drain in order
    idx[0] = 0;
    idx[1] = 0;
    turn = 0;
    while (idx[0] < m[0].size() || idx[1] < m[1].size()) begin
      s = turn;
      if (idx[s] >= m[s].size()) s = 1 - s;
      do begin
        b = m[s][idx[s]];
        idx[s]++;
        exp_q.push_back('{src: s[0], data: b.data});
      end while (!b.last);
      turn = 1 - s;
    end
    @(posedge clk); #1;
    s0_q = m[0];
    s1_q = m[1];
    wait_idle("random_traffic");
    repeat (10) @(negedge clk);
    check("random_err_busy_all_seen", 32'(err_exp.size()), 32'd0);
    check("random_aborts", 32'(abort_log.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
